// File: rtl/dar_cmd_pkg.sv
// Shared types and constants for the byte-stream register-file command controller.
package dar_cmd_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Header byte: bit 7 selects write (1) or read (0), low bits carry the address
    localparam int HDR_RW_BIT = 7;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/dar_cmd_ctrl_wdog.sv
// Idle-cycle watchdog for the WDATA state: counts consecutive idle cycles and
// flags expiry on the cycle the count would reach LIMIT. Only built when
// DAR_CMD_TIMEOUT_EN is defined.
module dar_cmd_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expire
);
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry fires on the LIMIT-th consecutive idle cycle
    assign expire = cnt_en && !clr && (cnt_q == CNT_W'(LIMIT - 1));

    // Next count: clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dar_cmd_ctrl.sv
// Byte-stream command controller for the 128 x 8 register file.
// Header byte: bit 7 = write(1)/read(0), low bits = address; writes carry one
// data byte. All outputs are registered and derived from the next state.
// Optional feature: define DAR_CMD_TIMEOUT_EN to abort a write stuck in WDATA
// after TIMEOUT_CYC idle cycles (pulses err_timeout).
module dar_cmd_ctrl
    import dar_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic              reg_w_en,
    output logic              reg_r_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              err_timeout
);

    if (TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("dar_cmd_ctrl: TIMEOUT_CYC must be nonzero");
    end

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              w_en_q, w_en_d;
    logic              r_en_q, r_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic cmd_hs;
    logic rsp_hs;
    logic wdog_expire;

    assign cmd_hs = cmd_valid && cmd_ready_q;
    assign rsp_hs = rsp_valid_q && rsp_ready;

`ifdef DAR_CMD_TIMEOUT_EN
    logic wdog_clr;
    logic wdog_en;

    // Counter is held clear outside WDATA (so it starts at zero on entry)
    // and on any cycle the sender presents a byte
    assign wdog_clr = (state_q != ST_WDATA) || cmd_valid;
    assign wdog_en  = (state_q == ST_WDATA);

    dar_cmd_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdog_clr),
        .cnt_en (wdog_en),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    // Next-state, latched fields and registered outputs decoded from the next state
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    addr_d  = cmd_data[ADDR_W-1:0];
                    state_d = cmd_data[HDR_RW_BIT] ? ST_WDATA : ST_READ;
                end
            end
            ST_WDATA: begin
                // A data handshake wins over a simultaneous expiry
                if (cmd_hs) begin
                    wdata_d = cmd_data;
                    state_d = ST_WRITE;
                end else if (wdog_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                rsp_data_d = reg_rdata;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_WDATA);
        w_en_d      = (state_d == ST_WRITE);
        r_en_d      = (state_d == ST_READ);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            w_en_q      <= 1'b0;
            r_en_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            w_en_q      <= w_en_d;
            r_en_q      <= r_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign reg_w_en    = w_en_q;
    assign reg_r_en    = r_en_q;
    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_dar_cmd_ctrl.sv
// Directed testbench for dar_cmd_ctrl with a behavioural 128 x 8 register file.
module tb_dar_cmd_ctrl;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned TIMEOUT_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;
    logic              reg_w_en;
    logic              reg_r_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              busy;
    logic              err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic              mem_clr;
    logic [DATA_W-1:0] mem [128];

    always #5 clk = ~clk;

    dar_cmd_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .reg_w_en    (reg_w_en),
        .reg_r_en    (reg_r_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    // Register file model
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
        end else if (reg_w_en) begin
            mem[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata = reg_r_en ? mem[reg_addr] : '0;

    // Strobe counters
    always @(posedge clk) begin
        if (reg_w_en) wr_cnt <= wr_cnt + 1;
        if (reg_r_en) rd_cnt <= rd_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted (bounded)
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready: cmd_ready=%b required 1 for byte %h", cmd_ready, b);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0; mem_clr = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({cmd_ready, rsp_valid, reg_w_en, reg_r_en, busy, err_timeout} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: rdy/rv/we/re/busy/err=%b required 000000",
                     {cmd_ready, rsp_valid, reg_w_en, reg_r_en, busy, err_timeout});
        end
        n_cmp++;
        if ({reg_addr, reg_wdata, rsp_data} !== 23'h0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h wdata=%h rsp=%h required 0", reg_addr, reg_wdata, rsp_data);
        end
        mem_clr = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: rdy/busy=%b required 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_cnt;
        send_byte(8'h85);
        n_cmp++;
        if ({busy, cmd_ready, reg_w_en, reg_addr} !== {3'b110, 7'h05}) begin
            n_err++;
            $display("FAIL write_hdr: busy/rdy/we=%b addr=%h required 110 addr 05",
                     {busy, cmd_ready, reg_w_en}, reg_addr);
        end
        send_byte(8'h3C);
        n_cmp++;
        if ({reg_w_en, cmd_ready, reg_addr, reg_wdata} !== {2'b10, 7'h05, 8'h3C}) begin
            n_err++;
            $display("FAIL write_strobe: we/rdy=%b addr=%h wdata=%h required 10 05 3c",
                     {reg_w_en, cmd_ready}, reg_addr, reg_wdata);
        end
        tick();
        n_cmp++;
        if ({reg_w_en, cmd_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL write_done: we/rdy/busy=%b required 010", {reg_w_en, cmd_ready, busy});
        end
        n_cmp++;
        if (mem[5] !== 8'h3C || wr_cnt !== w0 + 1) begin
            n_err++;
            $display("FAIL write_mem: mem5=%h writes=%0d required 3c and %0d", mem[5], wr_cnt - w0, 1);
        end
    endtask

    task automatic test_read();
        int r0;
        r0 = rd_cnt;
        rsp_ready = 1'b1;
        send_byte(8'h05);
        n_cmp++;
        if ({reg_r_en, rsp_valid, cmd_ready, reg_addr} !== {3'b100, 7'h05}) begin
            n_err++;
            $display("FAIL read_strobe: re/rv/rdy=%b addr=%h required 100 05",
                     {reg_r_en, rsp_valid, cmd_ready}, reg_addr);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, reg_r_en, rsp_data} !== {2'b10, 8'h3C}) begin
            n_err++;
            $display("FAIL read_rsp: rv/re=%b data=%h required 10 3c", {rsp_valid, reg_r_en}, rsp_data);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010 || rd_cnt !== r0 + 1) begin
            n_err++;
            $display("FAIL read_done: rv/rdy/busy=%b reads=%0d required 010 and 1",
                     {rsp_valid, cmd_ready, busy}, rd_cnt - r0);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_stall();
        send_byte(8'hFF);
        send_byte(8'h5A);
        tick();
        rsp_ready = 1'b0;
        send_byte(8'h7F);
        tick();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({rsp_valid, cmd_ready, rsp_data} !== {2'b10, 8'h5A}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: rv/rdy=%b data=%h required 10 5a",
                         i, {rsp_valid, cmd_ready}, rsp_data);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL stall_release: rv/rdy=%b required 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_cnt;
        send_byte(8'h81);
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({busy, cmd_ready, reg_addr, reg_wdata} !== 17'h0) begin
            n_err++;
            $display("FAIL midreset_state: busy/rdy=%b addr=%h wdata=%h required 00 0 0",
                     {busy, cmd_ready}, reg_addr, reg_wdata);
        end
        rst_n = 1'b1;
        tick();
        send_byte(8'hAA);
        n_cmp++;
        if ({busy, cmd_ready, reg_w_en, reg_addr} !== {3'b110, 7'h2A} || wr_cnt !== w0) begin
            n_err++;
            $display("FAIL midreset_hdr: busy/rdy/we=%b addr=%h writes=%0d required 110 2a 0",
                     {busy, cmd_ready, reg_w_en}, reg_addr, wr_cnt - w0);
        end
        send_byte(8'h77);
        tick();
        n_cmp++;
        if (mem[8'h2A] !== 8'h77 || wr_cnt !== w0 + 1) begin
            n_err++;
            $display("FAIL midreset_write: mem2a=%h writes=%0d required 77 and 1", mem[8'h2A], wr_cnt - w0);
        end
    endtask

    task automatic test_timeout();
        int w0;
        w0 = wr_cnt;
        send_byte(8'h90);
`ifdef DAR_CMD_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({busy, err_timeout} !== 2'b10) begin
                n_err++;
                $display("FAIL timeout_wait[%0d]: busy/err=%b required 10", i, {busy, err_timeout});
            end
        end
        tick();
        n_cmp++;
        if ({busy, cmd_ready, err_timeout} !== 3'b011) begin
            n_err++;
            $display("FAIL timeout_fire: busy/rdy/err=%b required 011", {busy, cmd_ready, err_timeout});
        end
        tick();
        n_cmp++;
        if (err_timeout !== 1'b0 || wr_cnt !== w0) begin
            n_err++;
            $display("FAIL timeout_after: err=%b writes=%0d required 0 and 0", err_timeout, wr_cnt - w0);
        end
`else
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if ({busy, cmd_ready, err_timeout} !== 3'b110 || wr_cnt !== w0) begin
            n_err++;
            $display("FAIL wdata_wait: busy/rdy/err=%b writes=%0d required 110 and 0",
                     {busy, cmd_ready, err_timeout}, wr_cnt - w0);
        end
        send_byte(8'h33);
        tick();
        n_cmp++;
        if (mem[8'h10] !== 8'h33 || wr_cnt !== w0 + 1) begin
            n_err++;
            $display("FAIL wdata_late: mem10=%h writes=%0d required 33 and 1", mem[8'h10], wr_cnt - w0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        int         idx, cyc, np;
        int         pc [2];
        logic [6:0] pa [2];
        logic [7:0] pd [2];
        logic       hs;
        seq[0] = 8'h81; seq[1] = 8'h11; seq[2] = 8'h82; seq[3] = 8'h22;
        idx = 0; cyc = 0; np = 0;
        pc[0] = 0; pc[1] = 0; pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        while (idx < 4 && cyc < 30) begin
            cmd_data = seq[idx];
            hs = cmd_ready;
            tick();
            cyc++;
            if (hs) idx++;
            if (reg_w_en) begin
                if (np < 2) begin
                    pc[np] = cyc; pa[np] = reg_addr; pd[np] = reg_wdata;
                end
                np++;
            end
        end
        cmd_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (np !== 2 || pc[1] - pc[0] !== 3) begin
            n_err++;
            $display("FAIL b2b_pulses: count=%0d spacing=%0d required 2 and 3", np, pc[1] - pc[0]);
        end
        n_cmp++;
        if ({pa[0], pd[0], pa[1], pd[1]} !== {7'h01, 8'h11, 7'h02, 8'h22}) begin
            n_err++;
            $display("FAIL b2b_fields: %h/%h %h/%h required 01/11 02/22", pa[0], pd[0], pa[1], pd[1]);
        end
        n_cmp++;
        if (mem[1] !== 8'h11 || mem[2] !== 8'h22 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_mem: mem1=%h mem2=%h rv=%b required 11 22 0", mem[1], mem[2], rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_stall();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
